// File: rtl/dma_mc_cntrl.sv
// dma_mc_cntrl: multi-channel burst DMA controller.
//
// NCH channels each own SRC/DST/LEN/CTRL registers on the host bus. Channels
// with GO set are served round-robin. Each grant moves a single burst of up
// to BURST words. The words are first read into an internal FIFO and then
// written out. The memory bus is released between bursts.
//
// Ports
//   clk0, reset_n          clock (rising edge), asynchronous active-low reset
//   host_cs/wr/addr/datain host register access, addr = {channel, reg[1:0]}
//   host_dataout           registered read data, valid the cycle after host_cs
//   dma_irq                registered OR over channels of (DONE & IE)
//   dma_busy               controller not idle
//   dma_bus_req/grant      memory-bus ownership handshake
//   mem_req/we/addr        beat request (held until mem_ack), direction, word address
//   mem_dataout/datain     write data out, read data in (valid with mem_ack)
//   mem_ack                beat complete
//
// Register map per channel: 0 SRC, 1 DST, 2 LEN, 3 CTRL
//   CTRL: b0 GO, b1 IE, b2 DONE (write 1 clears), b3 SRC_FIX, b4 DST_FIX
//
// Optional feature: define DMA_FIXED_ADDR_EN to implement SRC_FIX/DST_FIX.
// A set fix bit holds that address constant, for example on a peripheral
// FIFO port. When the macro is undefined, b3/b4 read as 0 and both
// addresses always increment.
module dma_mc_cntrl #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int AW    = 24,
  parameter int LW    = 16,
  parameter int BURST = 4
) (
  input  logic                      clk0,
  input  logic                      reset_n,
  input  logic                      host_cs,
  input  logic                      host_wr,
  input  logic [2+$clog2(NCH)-1:0]  host_addr,
  input  logic [DW-1:0]             host_datain,
  output logic [DW-1:0]             host_dataout,
  output logic                      dma_irq,
  output logic                      dma_busy,
  output logic                      dma_bus_req,
  input  logic                      dma_bus_grant,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_dataout,
  input  logic [DW-1:0]             mem_datain,
  input  logic                      mem_ack
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(BURST);
  localparam int PW1 = PW + 1;
  localparam logic [LW-1:0]  BURST_LEN = LW'(BURST);
  localparam logic [PW1-1:0] BURST_CNT = PW1'(BURST);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_RD, S_WR, S_REL} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]  src_q [NCH];
  logic [AW-1:0]  dst_q [NCH];
  logic [LW-1:0]  len_q [NCH];
  logic [NCH-1:0] go_q, ie_q, done_q;
  logic [NCH-1:0] sfix, dfix;

  logic [CHW-1:0] cur_q, rr_q;
  logic [PW1-1:0] beats_q, cnt_q;
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [DW-1:0]  fifo_q [BURST];
  logic [DW-1:0]  host_dataout_q;
  logic           irq_q;

  // Host decode
  logic [CHW-1:0] host_ch;
  logic [1:0]     host_reg;
  logic           host_we;
  logic [DW-1:0]  rd_data;
  logic           unused_bits;

  assign host_reg    = host_addr[1:0];
  assign host_we     = host_cs & host_wr;
  assign unused_bits = ^(host_datain >> AW);

  generate
    if (NCH > 1) begin : g_multi
      assign host_ch = host_addr[2+CHW-1:2];
    end else begin : g_single
      logic unused_addr;
      assign unused_addr = ^host_addr;
      assign host_ch = '0;
    end
  endgenerate

`ifdef DMA_FIXED_ADDR_EN
  logic [NCH-1:0] sfix_q, dfix_q;
  assign sfix = sfix_q;
  assign dfix = dfix_q;
`else
  assign sfix = '0;
  assign dfix = '0;
`endif

  // Round-robin pick: first GO channel at or above rr_q, otherwise the lowest GO channel
  logic           hi_found, lo_found, arb_found;
  logic [CHW-1:0] hi_ch, lo_ch, arb_ch;
  logic [LW-1:0]  arb_len, cur_len;
  logic [PW1-1:0] arb_beats;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hi_found && go_q[i] && (CHW'(i) >= rr_q)) begin
        hi_found = 1'b1;
        hi_ch    = CHW'(i);
      end
      if (!lo_found && go_q[i]) begin
        lo_found = 1'b1;
        lo_ch    = CHW'(i);
      end
    end
    arb_found = hi_found | lo_found;
    arb_ch    = hi_found ? hi_ch : lo_ch;
  end

  assign arb_len   = len_q[arb_ch];
  assign cur_len   = len_q[cur_q];
  assign arb_beats = (arb_len < BURST_LEN) ? arb_len[PW:0] : BURST_CNT;

  // Beat strobes. A bus-grant drop masks mem_req, so the beat stalls.
  logic beat_req, rd_beat, wr_beat, in_service;
  logic arb_done, rel_done;
  logic [NCH-1:0] done_set;

  assign beat_req   = ((state_q == S_RD) || (state_q == S_WR)) && dma_bus_grant;
  assign rd_beat    = (state_q == S_RD) && beat_req && mem_ack;
  assign wr_beat    = (state_q == S_WR) && beat_req && mem_ack;
  assign in_service = (state_q == S_REQ) || (state_q == S_RD) ||
                      (state_q == S_WR)  || (state_q == S_REL);
  assign arb_done   = (state_q == S_ARB) && arb_found && (arb_len == '0);
  // A channel whose GO was cleared mid-burst stops here without DONE
  assign rel_done   = (state_q == S_REL) && (cur_len == '0) && go_q[cur_q];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      done_set[i] = (arb_done && (arb_ch == CHW'(i))) ||
                    (rel_done && (cur_q == CHW'(i)));
    end
  end

  // FSM state register
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|go_q) state_d = S_ARB;
      S_ARB:   state_d = (arb_found && (arb_len != '0)) ? S_REQ : S_IDLE;
      S_REQ:   if (dma_bus_grant) state_d = S_RD;
      S_RD:    if (rd_beat && (beats_q == PW1'(1))) state_d = S_WR;
      S_WR:    if (wr_beat && (cnt_q == PW1'(1))) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dma_busy    = (state_q != S_IDLE);
    dma_bus_req = (state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WR);
    mem_req     = beat_req;
    mem_we      = (state_q == S_WR);
    mem_addr    = '0;
    mem_dataout = '0;
    if (state_q == S_RD) begin
      mem_addr = src_q[cur_q];
    end else if (state_q == S_WR) begin
      mem_addr    = dst_q[cur_q];
      mem_dataout = fifo_q[rptr_q];
    end
  end

  // Burst bookkeeping: channel in service, remaining reads, round-robin pointer
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      cur_q   <= '0;
      beats_q <= '0;
      rr_q    <= '0;
    end else begin
      if ((state_q == S_ARB) && arb_found && (arb_len != '0)) begin
        cur_q   <= arb_ch;
        beats_q <= arb_beats;
      end
      if (rd_beat) beats_q <= beats_q - PW1'(1);
      if (state_q == S_REL) rr_q <= (cur_q == CHW'(NCH - 1)) ? '0 : cur_q + CHW'(1);
    end
  end

  // FIFO pointers. Reset empties the FIFO, which discards any partial burst.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (rd_beat) begin
        wptr_q <= wptr_q + PW'(1);
        cnt_q  <= cnt_q + PW1'(1);
      end else if (wr_beat) begin
        rptr_q <= rptr_q + PW'(1);
        cnt_q  <= cnt_q - PW1'(1);
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rd_beat) fifo_q[wptr_q] <= mem_datain;
  end

  // Channel registers. Hardware DONE/GO updates come last so they beat a same-cycle host W1C.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
      go_q   <= '0;
      ie_q   <= '0;
      done_q <= '0;
`ifdef DMA_FIXED_ADDR_EN
      sfix_q <= '0;
      dfix_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (host_we && (host_ch == CHW'(i))) begin
          case (host_reg)
            2'd0: if (!(in_service && (cur_q == CHW'(i)))) src_q[i] <= host_datain[AW-1:0];
            2'd1: if (!(in_service && (cur_q == CHW'(i)))) dst_q[i] <= host_datain[AW-1:0];
            2'd2: if (!(in_service && (cur_q == CHW'(i)))) len_q[i] <= host_datain[LW-1:0];
            default: begin
              go_q[i] <= host_datain[0];
              ie_q[i] <= host_datain[1];
              if (host_datain[2]) done_q[i] <= 1'b0;
`ifdef DMA_FIXED_ADDR_EN
              sfix_q[i] <= host_datain[3];
              dfix_q[i] <= host_datain[4];
`endif
            end
          endcase
        end
        if (cur_q == CHW'(i)) begin
          if (rd_beat) begin
            if (!sfix[i]) src_q[i] <= src_q[i] + AW'(1);
            if (len_q[i] != '0) len_q[i] <= len_q[i] - LW'(1);
          end
          if (wr_beat && !dfix[i]) dst_q[i] <= dst_q[i] + AW'(1);
        end
        if (done_set[i]) begin
          done_q[i] <= 1'b1;
          go_q[i]   <= 1'b0;
        end
      end
    end
  end

  // Host read mux
  always_comb begin
    rd_data = '0;
    case (host_reg)
      2'd0: rd_data[AW-1:0] = src_q[host_ch];
      2'd1: rd_data[AW-1:0] = dst_q[host_ch];
      2'd2: rd_data[LW-1:0] = len_q[host_ch];
      default: begin
        rd_data[0] = go_q[host_ch];
        rd_data[1] = ie_q[host_ch];
        rd_data[2] = done_q[host_ch];
        rd_data[3] = sfix[host_ch];
        rd_data[4] = dfix[host_ch];
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      host_dataout_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      if (host_cs && !host_wr) host_dataout_q <= rd_data;
      irq_q <= |(done_q & ie_q);
    end
  end

  assign host_dataout = host_dataout_q;
  assign dma_irq      = irq_q;

endmodule

// File: tb/tb_dma_mc_cntrl.sv
module tb_dma_mc_cntrl;

  logic        clk0 = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_cs = 1'b0;
  logic        host_wr = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [31:0] host_datain = '0;
  logic [31:0] host_dataout;
  logic        dma_irq, dma_busy, dma_bus_req, dma_bus_grant;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [31:0] mem_dataout, mem_datain;
  logic        grant_en = 1'b1;

  int checks = 0;
  int fails  = 0;

  always #5 clk0 = ~clk0;

  function automatic logic [31:0] pat(input logic [23:0] a);
    return {8'hD0, a};
  endfunction

  assign dma_bus_grant = dma_bus_req & grant_en;
  assign mem_ack       = mem_req;
  assign mem_datain    = pat(mem_addr);

  dma_mc_cntrl dut (
    .clk0(clk0), .reset_n(reset_n),
    .host_cs(host_cs), .host_wr(host_wr), .host_addr(host_addr),
    .host_datain(host_datain), .host_dataout(host_dataout),
    .dma_irq(dma_irq), .dma_busy(dma_busy),
    .dma_bus_req(dma_bus_req), .dma_bus_grant(dma_bus_grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dataout(mem_dataout), .mem_datain(mem_datain), .mem_ack(mem_ack)
  );

  // Bus monitor: beat logs, bus-request rises (one per burst), reads per burst
  int          rises = 0;
  logic        req_prev = 1'b0;
  int          burst_rd [64];
  logic [23:0] burst_first [64];
  logic [23:0] rd_log [$];
  logic [23:0] wr_log [$];
  logic [31:0] wd_log [$];

  always @(posedge clk0) begin
    if (mem_req && mem_ack) begin
      if (!mem_we) begin
        rd_log.push_back(mem_addr);
        if (rises > 0 && rises <= 64) begin
          if (burst_rd[rises-1] == 0) burst_first[rises-1] = mem_addr;
          burst_rd[rises-1]++;
        end
      end else begin
        wr_log.push_back(mem_addr);
        wd_log.push_back(mem_dataout);
      end
    end
    if (dma_bus_req && !req_prev) rises++;
    req_prev = dma_bus_req;
  end

  task automatic host_write(input int ch, input int r, input logic [31:0] d);
    @(negedge clk0);
    host_cs = 1'b1; host_wr = 1'b1; host_addr = 3'((ch << 2) | r); host_datain = d;
    @(negedge clk0);
    host_cs = 1'b0; host_wr = 1'b0;
  endtask

  task automatic host_read(input int ch, input int r, output logic [31:0] d);
    @(negedge clk0);
    host_cs = 1'b1; host_wr = 1'b0; host_addr = 3'((ch << 2) | r);
    @(negedge clk0);
    host_cs = 1'b0;
    d = host_dataout;
  endtask

  task automatic setup(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    host_write(ch, 0, s);
    host_write(ch, 1, d);
    host_write(ch, 2, l);
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk0);
      n++;
      if (!dma_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      checks++; fails++;
      $display("FAIL %s_idle_timeout: dma_busy=%0b required 0", nm, dma_busy);
    end
  endtask

  task automatic check_reg(input string nm, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] v;
    host_read(ch, r, v);
    checks++;
    if (v !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, v, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk0);
    reset_n = 1'b1;
    @(negedge clk0);
    checks++; if ({dma_irq, dma_busy, dma_bus_req, mem_req, mem_we} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl_outs: got %b required 00000", {dma_irq, dma_busy, dma_bus_req, mem_req, mem_we});
    end
    checks++; if (mem_addr !== 24'h0 || mem_dataout !== 32'h0 || host_dataout !== 32'h0) begin
      fails++; $display("FAIL reset_data_outs: addr %h wdata %h hdata %h required 0", mem_addr, mem_dataout, host_dataout);
    end
    check_reg("reset_src0", 0, 0, 32'h0);
    check_reg("reset_ctrl1", 1, 3, 32'h0);
  endtask

  task automatic test_basic();
    int r0 = rd_log.size();
    int w0 = wr_log.size();
    int b0 = rises;
    setup(0, 32'h100, 32'h200, 32'd4);
    host_write(0, 3, 32'h3);
    wait_idle("basic");
    checks++; if (rises - b0 !== 1) begin fails++; $display("FAIL basic_bursts: got %0d required 1", rises - b0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r0 + k >= rd_log.size() || rd_log[r0+k] !== 24'(32'h100 + k)) begin
        fails++; $display("FAIL basic_rd_addr%0d: got %h required %h", k, (r0 + k < rd_log.size()) ? rd_log[r0+k] : 24'hx, 24'(32'h100 + k));
      end
      checks++;
      if (w0 + k >= wr_log.size() || wr_log[w0+k] !== 24'(32'h200 + k) || wd_log[w0+k] !== pat(24'(32'h100 + k))) begin
        fails++; $display("FAIL basic_wr%0d: got addr/data %h/%h required %h/%h", k,
                          (w0 + k < wr_log.size()) ? wr_log[w0+k] : 24'hx, (w0 + k < wd_log.size()) ? wd_log[w0+k] : 32'hx,
                          24'(32'h200 + k), pat(24'(32'h100 + k)));
      end
    end
    checks++; if (dma_irq !== 1'b1) begin fails++; $display("FAIL basic_irq: got %b required 1", dma_irq); end
    check_reg("basic_ctrl", 0, 3, 32'h6);
    check_reg("basic_src", 0, 0, 32'h104);
    check_reg("basic_dst", 0, 1, 32'h204);
    check_reg("basic_len", 0, 2, 32'h0);
    host_write(0, 3, 32'h4);
    repeat (2) @(negedge clk0);
    checks++; if (dma_irq !== 1'b0) begin fails++; $display("FAIL basic_irq_clear: got %b required 0", dma_irq); end
    check_reg("basic_done_w1c", 0, 3, 32'h0);
  endtask

  task automatic test_multi_burst();
    int r0 = rd_log.size();
    int w0 = wr_log.size();
    int b0 = rises;
    int exp_b [3] = '{4, 4, 2};
    setup(0, 32'h300, 32'h400, 32'd10);
    host_write(0, 3, 32'h1);
    wait_idle("multi");
    checks++; if (rises - b0 !== 3) begin fails++; $display("FAIL multi_bursts: got %0d required 3", rises - b0); end
    for (int b = 0; b < 3; b++) begin
      checks++; if (burst_rd[b0+b] !== exp_b[b]) begin
        fails++; $display("FAIL multi_burst%0d_len: got %0d required %0d", b, burst_rd[b0+b], exp_b[b]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (w0 + k >= wr_log.size() || rd_log[r0+k] !== 24'(32'h300 + k) ||
          wr_log[w0+k] !== 24'(32'h400 + k) || wd_log[w0+k] !== pat(24'(32'h300 + k))) begin
        fails++; $display("FAIL multi_beat%0d: got rd %h wr %h data %h required %h %h %h", k,
                          (r0 + k < rd_log.size()) ? rd_log[r0+k] : 24'hx, (w0 + k < wr_log.size()) ? wr_log[w0+k] : 24'hx,
                          (w0 + k < wd_log.size()) ? wd_log[w0+k] : 32'hx, 24'(32'h300 + k), 24'(32'h400 + k), pat(24'(32'h300 + k)));
      end
    end
    check_reg("multi_len", 0, 2, 32'h0);
    check_reg("multi_ctrl", 0, 3, 32'h4);
  endtask

  task automatic test_two_channel();
    int w0 = wr_log.size();
    int b0 = rises;
    logic [23:0] ea, es;
    logic [23:0] exp_first [4] = '{24'h1000, 24'h3000, 24'h1004, 24'h3004};
    setup(0, 32'h1000, 32'h2000, 32'd8);
    setup(1, 32'h3000, 32'h4000, 32'd8);
    host_write(0, 3, 32'h5);
    host_write(1, 3, 32'h5);
    wait_idle("two_ch");
    checks++; if (rises - b0 !== 4) begin fails++; $display("FAIL two_ch_bursts: got %0d required 4", rises - b0); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (burst_first[b0+b] !== exp_first[b] || burst_rd[b0+b] !== 4) begin
        fails++; $display("FAIL two_ch_burst%0d: got first %h len %0d required %h len 4", b, burst_first[b0+b], burst_rd[b0+b], exp_first[b]);
      end
      for (int k = 0; k < 4; k++) begin
        ea = 24'(((b % 2 == 0) ? 32'h2000 : 32'h4000) + (b / 2) * 4 + k);
        es = 24'(((b % 2 == 0) ? 32'h1000 : 32'h3000) + (b / 2) * 4 + k);
        checks++;
        if (w0 + b*4 + k >= wr_log.size() || wr_log[w0+b*4+k] !== ea || wd_log[w0+b*4+k] !== pat(es)) begin
          fails++; $display("FAIL two_ch_wr%0d_%0d: got %h/%h required %h/%h", b, k,
                            (w0 + b*4 + k < wr_log.size()) ? wr_log[w0+b*4+k] : 24'hx,
                            (w0 + b*4 + k < wd_log.size()) ? wd_log[w0+b*4+k] : 32'hx, ea, pat(es));
        end
      end
    end
    check_reg("two_ch_ctrl0", 0, 3, 32'h4);
    check_reg("two_ch_ctrl1", 1, 3, 32'h4);
  endtask

  task automatic test_len_zero();
    int b0 = rises;
    host_write(1, 2, 32'h0);
    host_write(1, 3, 32'h5);
    wait_idle("len0");
    checks++; if (rises !== b0) begin fails++; $display("FAIL len0_bus_req: got %0d bursts required 0", rises - b0); end
    check_reg("len0_ctrl", 1, 3, 32'h4);
    checks++; if (dma_irq !== 1'b0) begin fails++; $display("FAIL len0_irq: got %b required 0", dma_irq); end
  endtask

  task automatic test_wrap();
    int r0 = rd_log.size();
    logic [23:0] exp_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    setup(0, 32'hFFFFFE, 32'h500, 32'd4);
    host_write(0, 3, 32'h5);
    wait_idle("wrap");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r0 + k >= rd_log.size() || rd_log[r0+k] !== exp_a[k]) begin
        fails++; $display("FAIL wrap_rd%0d: got %h required %h", k, (r0 + k < rd_log.size()) ? rd_log[r0+k] : 24'hx, exp_a[k]);
      end
    end
    check_reg("wrap_src", 0, 0, 32'h2);
  endtask

  task automatic test_grant_drop();
    int w0 = wr_log.size();
    int wn;
    int n = 0;
    setup(0, 32'h600, 32'h700, 32'd4);
    host_write(0, 3, 32'h5);
    while (!(mem_req && mem_we) && n < 200) begin @(negedge clk0); n++; end
    if (n >= 200) begin
      checks++; fails++; $display("FAIL grant_wr_timeout: mem_we=%b required 1", mem_we);
    end
    @(negedge clk0);
    grant_en = 1'b0;
    wn = wr_log.size();
    checks++; if (wn - w0 !== 1) begin fails++; $display("FAIL grant_beats_before: got %0d required 1", wn - w0); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk0);
      checks++; if (mem_req !== 1'b0 || dma_bus_req !== 1'b1) begin
        fails++; $display("FAIL grant_stall%0d: got mem_req %b bus_req %b required 0 1", c, mem_req, dma_bus_req);
      end
    end
    checks++; if (wr_log.size() !== wn) begin fails++; $display("FAIL grant_no_beat: got %0d beats required %0d", wr_log.size(), wn); end
    grant_en = 1'b1;
    wait_idle("grant");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (w0 + k >= wr_log.size() || wr_log[w0+k] !== 24'(32'h700 + k) || wd_log[w0+k] !== pat(24'(32'h600 + k))) begin
        fails++; $display("FAIL grant_wr%0d: got %h/%h required %h/%h", k,
                          (w0 + k < wr_log.size()) ? wr_log[w0+k] : 24'hx, (w0 + k < wd_log.size()) ? wd_log[w0+k] : 32'hx,
                          24'(32'h700 + k), pat(24'(32'h600 + k)));
      end
    end
    check_reg("grant_ctrl", 0, 3, 32'h4);
  endtask

  task automatic test_reset_mid();
    int w0 = wr_log.size();
    int n = 0;
    setup(1, 32'h800, 32'h900, 32'd4);
    host_write(1, 3, 32'h5);
    while (!(mem_req && !mem_we) && n < 200) begin @(negedge clk0); n++; end
    if (n >= 200) begin
      checks++; fails++; $display("FAIL rstmid_rd_timeout: mem_req=%b required 1", mem_req);
    end
    @(negedge clk0);
    reset_n = 1'b0;
    #1;
    checks++; if ({dma_irq, dma_busy, dma_bus_req, mem_req, mem_we} !== 5'b0) begin
      fails++; $display("FAIL rstmid_ctrl_outs: got %b required 00000", {dma_irq, dma_busy, dma_bus_req, mem_req, mem_we});
    end
    checks++; if (mem_addr !== 24'h0 || mem_dataout !== 32'h0 || host_dataout !== 32'h0) begin
      fails++; $display("FAIL rstmid_data_outs: addr %h wdata %h hdata %h required 0", mem_addr, mem_dataout, host_dataout);
    end
    repeat (2) @(negedge clk0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk0);
    checks++; if (dma_busy !== 1'b0 || wr_log.size() !== w0) begin
      fails++; $display("FAIL rstmid_idle: got busy %b writes %0d required 0 0", dma_busy, wr_log.size() - w0);
    end
    check_reg("rstmid_ctrl", 1, 3, 32'h0);
    check_reg("rstmid_len", 1, 2, 32'h0);
  endtask

  task automatic test_fixed_addr();
    int r0;
    int w0;
    logic [23:0] ea;
    host_write(0, 3, 32'h18);
`ifdef DMA_FIXED_ADDR_EN
    check_reg("fix_ctrl_bits", 0, 3, 32'h18);
`else
    check_reg("fix_ctrl_bits", 0, 3, 32'h0);
`endif
    r0 = rd_log.size();
    w0 = wr_log.size();
    setup(0, 32'h40, 32'hA00, 32'd3);
    host_write(0, 3, 32'h9);
    wait_idle("fix");
    for (int k = 0; k < 3; k++) begin
`ifdef DMA_FIXED_ADDR_EN
      ea = 24'h40;
`else
      ea = 24'(32'h40 + k);
`endif
      checks++;
      if (w0 + k >= wr_log.size() || rd_log[r0+k] !== ea || wr_log[w0+k] !== 24'(32'hA00 + k) || wd_log[w0+k] !== pat(ea)) begin
        fails++; $display("FAIL fix_beat%0d: got rd %h wr %h data %h required %h %h %h", k,
                          (r0 + k < rd_log.size()) ? rd_log[r0+k] : 24'hx, (w0 + k < wr_log.size()) ? wr_log[w0+k] : 24'hx,
                          (w0 + k < wd_log.size()) ? wd_log[w0+k] : 32'hx, ea, 24'(32'hA00 + k), pat(ea));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_burst();
    test_two_channel();
    test_len_zero();
    test_wrap();
    test_grant_drop();
    test_reset_mid();
    test_fixed_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
